fifo_stream_reader: RTL and testbench

//   Read-side master for synchronous_fifo. Drains the FIFO through its r_en/data_out/empty port.

---
 rtl/fifo_stream_reader.sv | 122 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous_fifo through its read port and
// presents the words on a valid/ready stream at one beat per cycle.
// A 3-entry skid buffer absorbs the one-cycle FIFO read latency. That lets
// fifo_rd_en be computed from local state only, with no path from m_ready.
// Every BURST_LEN-th beat is flagged with m_last, and accepted beats are counted.
module fifo_stream_reader #(
  parameter int DATAWIDTH = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATAWIDTH-1:0] fifo_rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [CNT_W-1:0]     beat_count,
  output logic                 busy
);

  localparam int DEPTH = 3;
  // Keep burst_idx at least one bit wide so that BURST_LEN=1 stays legal.
  localparam int BI_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(BURST_LEN - 1);

  // Skid buffer storage and bookkeeping.
  logic [DEPTH-1:0][DATAWIDTH-1:0] skid_q, skid_d;
  logic [1:0]                      occ_q, occ_d;
  logic [1:0]                      rd_ptr_q, rd_ptr_d;
  logic [1:0]                      wr_ptr_q, wr_ptr_d;
  logic                            inflight_q, inflight_d;
  logic [BI_W-1:0]                 burst_idx_q, burst_idx_d;
  logic [CNT_W-1:0]                beat_count_q, beat_count_d;

  logic has_room;
  logic capture;
  logic xfer;

  // 2-bit pointer that wraps 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue: a slot must be free for every word that is buffered or in
  // flight. Gating with reset_n keeps the FIFO untouched while reset is applied.
  always_comb begin
    has_room   = ({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3;
    fifo_rd_en = reset_n & enable & ~fifo_empty & has_room;
  end

  // Stream-side outputs come straight from registered state.
  always_comb begin
    m_valid    = (occ_q != 2'd0);
    m_data     = skid_q[rd_ptr_q];
    m_last     = m_valid & (burst_idx_q == LAST_IDX);
    beat_count = beat_count_q;
    busy       = inflight_q | (occ_q != 2'd0);
  end

  // Next-state: capture the popped word, retire accepted beats, and track burst and count.
  always_comb begin
    capture      = inflight_q;
    xfer         = m_valid & m_ready;
    skid_d       = skid_q;
    occ_d        = occ_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    burst_idx_d  = burst_idx_q;
    beat_count_d = beat_count_q;
    inflight_d   = fifo_rd_en;

    if (capture) begin
      skid_d[wr_ptr_q] = fifo_rdata;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    if (xfer) begin
      rd_ptr_d     = ptr_inc(rd_ptr_q);
      beat_count_d = beat_count_q + CNT_W'(1);
      burst_idx_d  = (burst_idx_q == LAST_IDX) ? '0 : burst_idx_q + BI_W'(1);
    end

    // A capture and a transfer in the same cycle leave occupancy unchanged.
    case ({capture, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers. A synchronous reset discards buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_q       <= '0;
      occ_q        <= 2'd0;
      rd_ptr_q     <= 2'd0;
      wr_ptr_q     <= 2'd0;
      inflight_q   <= 1'b0;
      burst_idx_q  <= '0;
      beat_count_q <= '0;
    end else begin
      skid_q       <= skid_d;
      occ_q        <= occ_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_q   <= inflight_d;
      burst_idx_q  <= burst_idx_d;
      beat_count_q <= beat_count_d;
    end
  end

  // Invariants: a read is never issued on an empty FIFO, and the buffer never overflows.
  a_no_rd_on_empty: assert property (@(posedge clk) disable iff (!reset_n)
    fifo_rd_en |-> !fifo_empty);
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    ({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd3);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader. The FIFO is modelled
// as a queue. Expected stream behaviour comes from a queue of popped words,
// each stamped with its pop cycle.
module tb_fifo_stream_reader;
  localparam int DW = 8, BL = 4, CW = 16;

  logic          clk = 1'b0;
  logic          reset_n, enable, fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_rdata, m_data;
  logic          m_valid, m_ready, m_last, busy;
  logic [CW-1:0] beat_count;

  fifo_stream_reader #(.DATAWIDTH(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .beat_count(beat_count), .busy(busy));

  always #5 clk = ~clk;

  int            vectors = 0, errs = 0;
  logic [DW-1:0] fq[$];      // model FIFO contents
  logic [DW-1:0] exp_q[$];   // words popped but not yet delivered, in order
  int            exp_cyc[$]; // cycle in which each of those words was popped
  int            cyc = 0, delivered = 0, rd_cnt = 0, pushed = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          s_valid, s_last, s_rden, s_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    pushed++;
    fifo_empty = 1'b0;
  endtask

  // One clock: check outputs at the negedge, then model the FIFO pop just after the posedge.
  task automatic cycle();
    logic pop, xfer, vexp;
    @(negedge clk);
    s_valid = m_valid; s_last = m_last; s_rden = fifo_rd_en; s_busy = busy;
    pop = fifo_rd_en;
    if (!reset_n) begin
      chk("rd_en_in_reset", fifo_rd_en, 0);
    end else begin
      chk("rd_en_on_empty", fifo_rd_en & fifo_empty, 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("occupancy", exp_q.size() <= 3, 1);
      vexp = 1'b0;
      if (exp_q.size() != 0) vexp = (cyc >= exp_cyc[0] + 2);
      chk("m_valid", m_valid, vexp);
      if (m_valid && exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0]);
        chk("m_last", m_last, (delivered % BL) == BL - 1);
      end else begin
        chk("m_last_idle", m_last, 0);
      end
      chk("beat_count", beat_count, delivered & 32'hffff);
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      xfer = m_valid & m_ready;
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      if (xfer && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(exp_cyc.pop_front());
        delivered++;
      end
      if (pop) rd_cnt++;
    end
    @(posedge clk); #1;
    if (!reset_n) begin
      // The FIFO is reset together with the reader.
      fq.delete(); exp_q.delete(); exp_cyc.delete();
      delivered = 0; prev_stall = 1'b0; pop = 1'b0;
    end
    if (pop && fq.size() != 0) begin
      fifo_rdata = fq.pop_front();
      exp_q.push_back(fifo_rdata);
      exp_cyc.push_back(cyc);
    end else begin
      fifo_rdata = DW'($urandom);
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  // Apply one reset cycle and check the cleared outputs. Returns with reset_n still low.
  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 60 && (fq.size() != 0 || exp_q.size() != 0); i++) cycle();
    chk(tag, fq.size() + exp_q.size(), 0);
    chk("drain_count", delivered, pushed);
  endtask

  initial begin
    logic [7:0]    vm8;
    logic [11:0]   vm12, lm12;
    logic [DW-1:0] w0;
    reset_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = '0;

    // T1: three preloaded words, stream always ready.
    do_reset();
    pushed = 0;
    push(8'h11); push(8'h22); push(8'h33);
    enable = 1'b1; m_ready = 1'b1; reset_n = 1'b1; rd_cnt = 0; vm8 = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      vm8[i] = s_valid;
      if (i == 0) chk("t1_rd_en_c0", s_rden, 1);
    end
    chk("t1_valid_pattern", vm8, 8'h1c);
    chk("t1_beats", beat_count, 3);
    chk("t1_busy", busy, 0);
    chk("t1_rd_cnt", rd_cnt, 3);

    // T2: eight words back to back, with m_last on every fourth beat.
    do_reset();
    pushed = 0;
    for (int i = 0; i < 8; i++) push(DW'(i));
    reset_n = 1'b1; vm12 = '0; lm12 = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      vm12[i] = s_valid; lm12[i] = s_last;
    end
    chk("t2_valid_pattern", vm12, 12'h3fc);
    chk("t2_last_pattern", lm12, 12'h220);
    chk("t2_beats", beat_count, 8);

    // T3: backpressure with six words queued.
    do_reset();
    pushed = 0;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    w0 = fq[0];
    m_ready = 1'b0; reset_n = 1'b1; rd_cnt = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t3_rd_pulses", rd_cnt, 3);
    chk("t3_valid_held", m_valid, 1);
    chk("t3_first_word", m_data, w0);
    chk("t3_fifo_left", fq.size(), 3);
    drain("t3_drained");

    // T4: alternating ready, FIFO kept non-empty.
    do_reset();
    pushed = 0;
    reset_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      while (fq.size() < 3) push(DW'($urandom));
      m_ready = i[0];
      cycle();
    end
    drain("t4_drained");

    // T4b: fully random enable, ready and FIFO fill.
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 1) != 0 && fq.size() < 6) push(DW'($urandom));
      cycle();
    end
    enable = 1'b1;
    drain("t4b_drained");

    // T5: enable drops right after the second read.
    do_reset();
    pushed = 0;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    enable = 1'b1; m_ready = 1'b1; reset_n = 1'b1; rd_cnt = 0;
    for (int i = 0; i < 10 && rd_cnt < 2; i++) cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t5_delivered", delivered, 2);
    chk("t5_fifo_left", fq.size(), 3);
    chk("t5_busy", busy, 0);

    // T6: reset while two words are buffered and one is in flight.
    do_reset();
    pushed = 0;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    enable = 1'b1; m_ready = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_pre_busy", busy, 1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("t6_m_valid", s_valid, 0);
    chk("t6_m_last", s_last, 0);
    chk("t6_rd_en", s_rden, 0);
    chk("t6_busy", s_busy, 0);
    chk("t6_beat_count", beat_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
